// File: rtl/nios_ii_cpu_ocimem_ctrl.sv
// rtl/nios_ii_cpu_ocimem_ctrl.sv - OCI debug-RAM access engine driven by JTAG ocimem strobes
// Single-word reads/writes with an auto-incrementing word address and sticky error flag.
module nios_ii_cpu_ocimem_ctrl #(
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              debugack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wrdata,
  output logic              ram_we,
  output logic              ram_rd,
  input  logic [31:0]       ram_rddata,
  output logic [31:0]       MonDReg,
  output logic [ADDR_W-1:0] MonAReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR} state_t;

  localparam logic [1:0] LAT = 2'(RD_LAT);

  state_t            state, state_nxt;
  logic [1:0]        cnt, cnt_nxt;
  logic [ADDR_W-1:0] a_nxt;
  logic [31:0]       d_nxt, wd_nxt;
  logic              rdy_nxt, err_nxt, rd_nxt, we_nxt;
  logic              err_set, err_clr, any_strobe;
  logic              unused_jdo;

  assign unused_jdo = ^{jdo[37:36], jdo[33:32]};
  assign any_strobe = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;

  // The RAM address always tracks the word pointer; it only matters while ram_rd/ram_we is high.
  assign ram_addr = MonAReg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      cnt           <= '0;
      MonAReg       <= '0;
      MonDReg       <= '0;
      ram_wrdata    <= '0;
      ram_rd        <= 1'b0;
      ram_we        <= 1'b0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      MonAReg       <= a_nxt;
      MonDReg       <= d_nxt;
      ram_wrdata    <= wd_nxt;
      ram_rd        <= rd_nxt;
      ram_we        <= we_nxt;
      monitor_ready <= rdy_nxt;
      monitor_error <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    a_nxt     = MonAReg;
    d_nxt     = MonDReg;
    wd_nxt    = ram_wrdata;
    rdy_nxt   = monitor_ready;
    rd_nxt    = 1'b0;
    we_nxt    = 1'b0;
    err_set   = 1'b0;
    err_clr   = 1'b0;
    case (state)
      IDLE: begin
        if (take_action_ocimem_a) begin
          a_nxt   = jdo[ADDR_W-1:0];
          err_clr = jdo[34];
          rdy_nxt = ~jdo[35];
          if (jdo[35]) begin
            rd_nxt    = 1'b1;
            cnt_nxt   = LAT;
            state_nxt = RD_WAIT;
          end
        end else if (take_action_ocimem_b) begin
          if (debugack) begin
            wd_nxt    = jdo[31:0];
            we_nxt    = 1'b1;
            rdy_nxt   = 1'b0;
            state_nxt = WR;
          end else begin
            err_set = 1'b1;
          end
        end else if (take_no_action_ocimem_a && jdo[35]) begin
          rd_nxt    = 1'b1;
          rdy_nxt   = 1'b0;
          cnt_nxt   = LAT;
          state_nxt = RD_WAIT;
        end
      end
      RD_WAIT: begin
        err_set = any_strobe;
        if (cnt == 2'd0) begin
          d_nxt     = ram_rddata;
          a_nxt     = MonAReg + 1'b1;
          rdy_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      WR: begin
        // ram_we is high during this state; a late debugack drop does not cancel it.
        err_set   = any_strobe;
        a_nxt     = MonAReg + 1'b1;
        rdy_nxt   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    err_nxt = (monitor_error & ~err_clr) | err_set;
  end

endmodule

// File: tb/tb_nios_ii_cpu_ocimem_ctrl.sv
// tb/tb_nios_ii_cpu_ocimem_ctrl.sv - self-checking bench for nios_ii_cpu_ocimem_ctrl
// Two instances (RD_LAT 1 and 3) share stimulus; a transaction-level model predicts outputs.
module tb_nios_ii_cpu_ocimem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [37:0] jdo;
  logic        a_stb, na_stb, b_stb, debugack;
  logic        ram_fill;

  logic [7:0]  ram_addr_o [2];
  logic [31:0] ram_wrdata_o [2];
  logic        ram_we_o [2];
  logic        ram_rd_o [2];
  logic [31:0] ram_rddata_i [2];
  logic [31:0] mon_d [2];
  logic [7:0]  mon_a [2];
  logic        rdy [2];
  logic        err [2];

  nios_ii_cpu_ocimem_ctrl #(.ADDR_W(8), .RD_LAT(1)) u_dut_lat1 (
    .clk(clk), .reset_n(reset_n), .jdo(jdo),
    .take_action_ocimem_a(a_stb), .take_no_action_ocimem_a(na_stb),
    .take_action_ocimem_b(b_stb), .debugack(debugack),
    .ram_addr(ram_addr_o[0]), .ram_wrdata(ram_wrdata_o[0]), .ram_we(ram_we_o[0]),
    .ram_rd(ram_rd_o[0]), .ram_rddata(ram_rddata_i[0]), .MonDReg(mon_d[0]),
    .MonAReg(mon_a[0]), .monitor_ready(rdy[0]), .monitor_error(err[0])
  );

  nios_ii_cpu_ocimem_ctrl #(.ADDR_W(8), .RD_LAT(3)) u_dut_lat3 (
    .clk(clk), .reset_n(reset_n), .jdo(jdo),
    .take_action_ocimem_a(a_stb), .take_no_action_ocimem_a(na_stb),
    .take_action_ocimem_b(b_stb), .debugack(debugack),
    .ram_addr(ram_addr_o[1]), .ram_wrdata(ram_wrdata_o[1]), .ram_we(ram_we_o[1]),
    .ram_rd(ram_rd_o[1]), .ram_rddata(ram_rddata_i[1]), .MonDReg(mon_d[1]),
    .MonAReg(mon_a[1]), .monitor_ready(rdy[1]), .monitor_error(err[1])
  );

  function automatic logic [31:0] fill_word(input int k);
    return {16'hC0DE, 8'h00, 8'(k)};
  endfunction

  // Debug RAM per instance: read data is driven only on the cycle it is valid, junk otherwise.
  logic [31:0] ram [2][256];
  logic [31:0] pipe_d [2][3];
  logic        pipe_v [2][3];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (ram_fill) begin
        for (int k = 0; k < 256; k++) ram[i][k] <= fill_word(k);
      end else if (ram_we_o[i]) begin
        ram[i][ram_addr_o[i]] <= ram_wrdata_o[i];
      end
      pipe_v[i][0] <= ram_rd_o[i];
      pipe_d[i][0] <= ram[i][ram_addr_o[i]];
      for (int s = 1; s < 3; s++) begin
        pipe_v[i][s] <= pipe_v[i][s-1];
        pipe_d[i][s] <= pipe_d[i][s-1];
      end
    end
  end

  assign ram_rddata_i[0] = pipe_v[0][0] ? pipe_d[0][0] : 32'hBADBAD01;
  assign ram_rddata_i[1] = pipe_v[1][2] ? pipe_d[1][2] : 32'hBADBAD03;

  // Model: each accepted op occupies the engine for a fixed number of edges, then completes.
  logic [7:0]  m_a [2];
  logic [31:0] m_d [2];
  logic [31:0] m_wd [2];
  logic        m_rdy [2], m_err [2], e_rd [2], e_we [2], p_read [2];
  int          busy [2];
  logic [31:0] ref_mem [2][256];

  int total = 0;
  int bad = 0;
  int cyc = 0;

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      int lat;
      lat = (i == 0) ? 1 : 3;
      if (!reset_n) begin
        m_a[i] = 8'h00; m_d[i] = 32'h0; m_wd[i] = 32'h0;
        m_rdy[i] = 1'b0; m_err[i] = 1'b0; e_rd[i] = 1'b0; e_we[i] = 1'b0;
        p_read[i] = 1'b0; busy[i] = 0;
      end else begin
        e_rd[i] = 1'b0;
        e_we[i] = 1'b0;
        if (busy[i] > 0) begin
          if (a_stb || na_stb || b_stb) m_err[i] = 1'b1;
          busy[i] = busy[i] - 1;
          if (busy[i] == 0) begin
            if (p_read[i]) m_d[i] = ref_mem[i][m_a[i]];
            m_a[i] = m_a[i] + 8'd1;
            m_rdy[i] = 1'b1;
          end
        end else if (a_stb) begin
          m_a[i] = jdo[7:0];
          if (jdo[34]) m_err[i] = 1'b0;
          m_rdy[i] = ~jdo[35];
          if (jdo[35]) begin
            e_rd[i] = 1'b1; p_read[i] = 1'b1; busy[i] = lat + 1;
          end
        end else if (b_stb) begin
          if (debugack) begin
            ref_mem[i][m_a[i]] = jdo[31:0];
            m_wd[i] = jdo[31:0];
            e_we[i] = 1'b1; p_read[i] = 1'b0; m_rdy[i] = 1'b0; busy[i] = 1;
          end else begin
            m_err[i] = 1'b1;
          end
        end else if (na_stb && jdo[35]) begin
          e_rd[i] = 1'b1; p_read[i] = 1'b1; m_rdy[i] = 1'b0; busy[i] = lat + 1;
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("MonAReg[%0d]", i), 32'(mon_a[i]), 32'(m_a[i]));
      chk($sformatf("MonDReg[%0d]", i), mon_d[i], m_d[i]);
      chk($sformatf("ready[%0d]", i), 32'(rdy[i]), 32'(m_rdy[i]));
      chk($sformatf("error[%0d]", i), 32'(err[i]), 32'(m_err[i]));
      chk($sformatf("ram_rd[%0d]", i), 32'(ram_rd_o[i]), 32'(e_rd[i]));
      chk($sformatf("ram_we[%0d]", i), 32'(ram_we_o[i]), 32'(e_we[i]));
      chk($sformatf("ram_wrdata[%0d]", i), ram_wrdata_o[i], m_wd[i]);
      if (e_rd[i] || e_we[i]) chk($sformatf("ram_addr[%0d]", i), 32'(ram_addr_o[i]), 32'(m_a[i]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  function automatic logic [37:0] mk(input logic rd, input logic clr, input logic [31:0] d);
    return {2'b00, rd, clr, 2'b00, d};
  endfunction

  initial begin
    reset_n = 1'b0; ram_fill = 1'b1; jdo = '0;
    a_stb = 1'b0; na_stb = 1'b0; b_stb = 1'b0; debugack = 1'b0;
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 256; k++) ref_mem[i][k] = fill_word(k);
    idle(3);
    reset_n = 1'b1; ram_fill = 1'b0;
    chk("reset MonAReg", 32'(mon_a[0]), 32'h0);
    chk("reset ready", 32'(rdy[1]), 32'h0);
    chk("reset MonDReg", mon_d[1], 32'h0);

    // address load without read
    a_stb = 1'b1; jdo = mk(1'b0, 1'b0, 32'h10); tick(); a_stb = 1'b0;
    chk("load MonAReg", 32'(mon_a[0]), 32'h10);
    chk("load ready", 32'(rdy[0]), 32'h1);
    chk("load no rd", 32'(ram_rd_o[0]), 32'h0);

    // write
    debugack = 1'b1; b_stb = 1'b1; jdo = mk(1'b0, 1'b0, 32'hDEADBEEF); tick(); b_stb = 1'b0;
    chk("wr we", 32'(ram_we_o[0]), 32'h1);
    chk("wr addr", 32'(ram_addr_o[0]), 32'h10);
    chk("wr data", ram_wrdata_o[0], 32'hDEADBEEF);
    tick();
    chk("wr we drop", 32'(ram_we_o[0]), 32'h0);
    chk("wr MonAReg", 32'(mon_a[0]), 32'h11);
    chk("wr ready", 32'(rdy[0]), 32'h1);

    // load+read back, latency RD_LAT+2
    a_stb = 1'b1; jdo = mk(1'b1, 1'b0, 32'h10); tick(); a_stb = 1'b0;
    chk("rd rd", 32'(ram_rd_o[0]), 32'h1);
    chk("rd addr", 32'(ram_addr_o[0]), 32'h10);
    tick();
    chk("rd ready early", 32'(rdy[0]), 32'h0);
    tick();
    chk("rd ready lat1", 32'(rdy[0]), 32'h1);
    chk("rd MonDReg lat1", mon_d[0], 32'hDEADBEEF);
    chk("rd MonAReg lat1", 32'(mon_a[0]), 32'h11);
    chk("rd ready lat3 early", 32'(rdy[1]), 32'h0);
    idle(2);
    chk("rd ready lat3", 32'(rdy[1]), 32'h1);
    chk("rd MonDReg lat3", mon_d[1], 32'hDEADBEEF);

    // address wrap on read-next
    a_stb = 1'b1; jdo = mk(1'b0, 1'b0, 32'hFF); tick(); a_stb = 1'b0;
    na_stb = 1'b1; jdo = mk(1'b1, 1'b0, 32'h0); tick(); na_stb = 1'b0;
    chk("wrap rd addr", 32'(ram_addr_o[0]), 32'hFF);
    idle(5);
    chk("wrap MonAReg", 32'(mon_a[0]), 32'h00);
    chk("wrap MonDReg", mon_d[1], 32'hC0DE00FF);
    chk("wrap error", 32'(err[0]), 32'h0);

    // write without debugack, then clear
    debugack = 1'b0; b_stb = 1'b1; jdo = mk(1'b0, 1'b0, 32'h12345678); tick(); b_stb = 1'b0;
    chk("nodbg we", 32'(ram_we_o[0]), 32'h0);
    chk("nodbg error", 32'(err[0]), 32'h1);
    tick();
    debugack = 1'b1;
    a_stb = 1'b1; jdo = mk(1'b0, 1'b1, 32'h20); tick(); a_stb = 1'b0;
    chk("clear error", 32'(err[0]), 32'h0);

    // strobe dropped while busy
    na_stb = 1'b1; jdo = mk(1'b1, 1'b0, 32'h0); tick(); na_stb = 1'b0;
    tick();
    na_stb = 1'b1; tick(); na_stb = 1'b0;
    chk("busy drop error", 32'(err[1]), 32'h1);
    idle(2);
    chk("busy ready", 32'(rdy[1]), 32'h1);
    chk("busy MonDReg", mon_d[1], 32'hC0DE0020);
    chk("busy MonAReg", 32'(mon_a[1]), 32'h21);

    // reset during RD_WAIT
    a_stb = 1'b1; jdo = mk(1'b1, 1'b1, 32'h30); tick(); a_stb = 1'b0;
    tick();
    reset_n = 1'b0; tick();
    chk("midrst MonAReg", 32'(mon_a[1]), 32'h0);
    chk("midrst rd", 32'(ram_rd_o[1]), 32'h0);
    reset_n = 1'b1; idle(5);
    chk("midrst MonDReg", mon_d[1], 32'h0);
    chk("midrst ready", 32'(rdy[1]), 32'h0);

    // randomized traffic
    for (int n = 0; n < 800; n++) begin
      a_stb    = ($urandom_range(0, 5) == 0);
      na_stb   = ($urandom_range(0, 4) == 0);
      b_stb    = ($urandom_range(0, 5) == 0);
      debugack = ($urandom_range(0, 7) != 0);
      jdo      = {6'($urandom), $urandom};
      reset_n  = ($urandom_range(0, 199) != 0);
      tick();
    end
    a_stb = 1'b0; na_stb = 1'b0; b_stb = 1'b0; reset_n = 1'b1;
    idle(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
